// File: rtl/ttpu_addr_pkg.sv
// Shared constants, sequencer state encoding and the lane-rank helper for the
// weight address sequencer.
package ttpu_addr_pkg;

    localparam int N_UNITS = 16;
    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 8;
    localparam int RANK_W  = $clog2(N_UNITS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        BIAS = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    // Number of enabled lanes strictly below idx: the lane's compacted position.
    function automatic logic [RANK_W-1:0] lane_rank(input logic [N_UNITS-1:0] mask,
                                                    input int idx);
        logic [RANK_W-1:0] cnt;
        cnt = {RANK_W{1'b0}};
        for (int i = 0; i < N_UNITS; i++) begin
            if (i < idx) begin
                cnt = cnt + {{(RANK_W-1){1'b0}}, mask[i]};
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/weight_addr_sequencer_if.sv
// Config handshake and per-lane address/bias bus of the weight address sequencer.
// The slave modport is the sequencer side, the master modport the controller side.
interface weight_addr_sequencer_if;
    import ttpu_addr_pkg::*;

    logic                        clear;
    logic                        cfg_valid;
    logic                        cfg_ready;
    logic [ADDR_W-1:0]           cfg_start_addr;
    logic [LEN_W-1:0]            cfg_kernel_size;
    logic [LEN_W-1:0]            cfg_stride;
    logic [LEN_W-1:0]            cfg_passes;
    logic [N_UNITS-1:0]          cfg_active;
    logic                        step;
    logic                        addr_valid;
    logic [N_UNITS*ADDR_W-1:0]   addr_out;
    logic                        bias_valid;
    logic [N_UNITS*ADDR_W-1:0]   bias_addr;
    logic                        busy;
    logic                        done;

    modport master (
        output clear, cfg_valid, cfg_start_addr, cfg_kernel_size, cfg_stride,
               cfg_passes, cfg_active, step,
        input  cfg_ready, addr_valid, addr_out, bias_valid, bias_addr, busy, done
    );

    modport slave (
        input  clear, cfg_valid, cfg_start_addr, cfg_kernel_size, cfg_stride,
               cfg_passes, cfg_active, step,
        output cfg_ready, addr_valid, addr_out, bias_valid, bias_addr, busy, done
    );

endinterface

// File: rtl/lane_rank_prefix.sv
// Combinational prefix popcount over the lane enable mask; rank[i] is the
// compacted slot of lane i among the enabled lanes.
module lane_rank_prefix
    import ttpu_addr_pkg::*;
(
    input  logic [N_UNITS-1:0]             mask,
    output logic [N_UNITS-1:0][RANK_W-1:0] rank
);

    // One prefix count per lane.
    always_comb begin
        rank = {(N_UNITS*RANK_W){1'b0}};
        for (int i = 0; i < N_UNITS; i++) begin
            rank[i] = lane_rank(mask, i);
        end
    end

endmodule

// File: rtl/weight_addr_sequencer.sv
// Multi-pass weight/bias address sequencer: latches a kernel config, compacts the
// enabled lanes by rank and walks every enabled lane through its kernel.
module weight_addr_sequencer
    import ttpu_addr_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    weight_addr_sequencer_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam int               PROD_W   = ADDR_W + LEN_W;

    seq_state_e          state_r;
    logic [ADDR_W-1:0]   start_r;
    logic [LEN_W-1:0]    ks_r;
    logic [LEN_W-1:0]    stride_r;
    logic [LEN_W-1:0]    passes_r;
    logic [N_UNITS-1:0]  active_r;
    logic [LEN_W-1:0]    elem_r;
    logic [LEN_W-1:0]    pass_r;
    logic                cfg_ready_r;
    logic                addr_valid_r;
    logic                bias_valid_r;
    logic                busy_r;
    logic                done_r;

    logic [N_UNITS-1:0][RANK_W-1:0] rank_s;
    logic [RANK_W-1:0]   total_s;
    logic [PROD_W-1:0]   total_prod_s;
    logic [LEN_W-1:0]    passes_eff_s;
    logic                last_elem_s;
    logic                last_pass_s;
    logic                run_step_s;
    logic                load_s;
    logic                rewind_s;
    logic                adv_s;
    wire  [N_UNITS*ADDR_W-1:0] addr_bus_s;
    wire  [N_UNITS*ADDR_W-1:0] bias_bus_s;

    lane_rank_prefix u_rank (
        .mask (active_r),
        .rank (rank_s)
    );

    // Lane-step control decoded from the current state and the consumer's step.
    always_comb begin
        total_s      = rank_s[N_UNITS-1] + {{(RANK_W-1){1'b0}}, active_r[N_UNITS-1]};
        total_prod_s = {{(PROD_W-RANK_W){1'b0}}, total_s} * {{ADDR_W{1'b0}}, ks_r};
        passes_eff_s = (passes_r == LEN_ZERO) ? LEN_ONE : passes_r;
        last_elem_s  = (elem_r == (ks_r - LEN_ONE));
        last_pass_s  = (pass_r >= (passes_eff_s - LEN_ONE));
        run_step_s   = (state_r == RUN) && bus.step && !bus.clear;
        load_s       = (state_r == LOAD) && !bus.clear;
        rewind_s     = run_step_s && last_elem_s && !last_pass_s;
        adv_s        = run_step_s && !last_elem_s;
    end

    // Sequencer FSM with its registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.clear) begin
            state_r      <= IDLE;
            start_r      <= {ADDR_W{1'b0}};
            ks_r         <= LEN_ZERO;
            stride_r     <= LEN_ZERO;
            passes_r     <= LEN_ZERO;
            active_r     <= {N_UNITS{1'b0}};
            elem_r       <= LEN_ZERO;
            pass_r       <= LEN_ZERO;
            cfg_ready_r  <= 1'b1;
            addr_valid_r <= 1'b0;
            bias_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cfg_valid && cfg_ready_r) begin
                        start_r     <= bus.cfg_start_addr;
                        ks_r        <= bus.cfg_kernel_size;
                        stride_r    <= bus.cfg_stride;
                        passes_r    <= bus.cfg_passes;
                        active_r    <= bus.cfg_active;
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= LOAD;
                    end
                end
                LOAD: begin
                    elem_r <= LEN_ZERO;
                    pass_r <= LEN_ZERO;
                    if (active_r == {N_UNITS{1'b0}}) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (ks_r == LEN_ZERO) begin
                        bias_valid_r <= 1'b1;
                        state_r      <= BIAS;
                    end else begin
                        addr_valid_r <= 1'b1;
                        state_r      <= RUN;
                    end
                end
                RUN: begin
                    if (bus.step) begin
                        if (!last_elem_s) begin
                            elem_r <= elem_r + LEN_ONE;
                        end else if (!last_pass_s) begin
                            elem_r <= LEN_ZERO;
                            pass_r <= pass_r + LEN_ONE;
                        end else begin
                            addr_valid_r <= 1'b0;
                            bias_valid_r <= 1'b1;
                            state_r      <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    if (bus.step) begin
                        bias_valid_r <= 1'b0;
                        done_r       <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    cfg_ready_r  <= 1'b1;
                    addr_valid_r <= 1'b0;
                    bias_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_UNITS; g++) begin : g_lane
            logic [ADDR_W-1:0] base_r;
            logic [ADDR_W-1:0] cur_r;
            logic [ADDR_W-1:0] bias_r;
            logic [PROD_W-1:0] base_prod_s;

            assign base_prod_s = {{(PROD_W-RANK_W){1'b0}}, rank_s[g]} * {{ADDR_W{1'b0}}, ks_r};

            // Disabled lanes are zeroed at LOAD so their outputs read 0 without a mask.
            always_ff @(posedge clk or posedge rst) begin
                if (rst || bus.clear) begin
                    base_r <= {ADDR_W{1'b0}};
                    cur_r  <= {ADDR_W{1'b0}};
                    bias_r <= {ADDR_W{1'b0}};
                end else if (load_s) begin
                    base_r <= active_r[g] ? start_r + base_prod_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
                    cur_r  <= active_r[g] ? start_r + base_prod_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
                    bias_r <= active_r[g] ? start_r + total_prod_s[ADDR_W-1:0]
                                            + {{(ADDR_W-RANK_W){1'b0}}, rank_s[g]}
                                          : {ADDR_W{1'b0}};
                end else if (rewind_s && active_r[g]) begin
                    cur_r <= base_r;
                end else if (adv_s && active_r[g]) begin
                    cur_r <= cur_r + {{(ADDR_W-LEN_W){1'b0}}, stride_r};
                end
            end

            assign addr_bus_s[g*ADDR_W +: ADDR_W] = cur_r;
            assign bias_bus_s[g*ADDR_W +: ADDR_W] = bias_r;
        end
    endgenerate

    assign bus.cfg_ready  = cfg_ready_r;
    assign bus.addr_valid = addr_valid_r;
    assign bus.addr_out   = addr_bus_s;
    assign bus.bias_valid = bias_valid_r;
    assign bus.bias_addr  = bias_bus_s;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule
